// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcodes, FSM states and status-word layout for the multi-cycle ALU
package alu_mc_pkg;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_NOT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NEGA = 4'h6;
  localparam logic [3:0] OP_NEGB = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SAR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit order of the status word handed to the control unit
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ERR   = 4;
  localparam int FLAG_W     = 5;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

  function automatic logic is_rsvd(input logic [3:0] op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - width-generic combinational datapath for the single-cycle ops
module alu_core
  import alu_mc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] y,
  output logic         carry,
  output logic         ovf
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum;
  logic [W:0] diff;

  // The extra top bit of diff is the unsigned borrow
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_PASS: y = a;
      OP_NOT:  y = ~a;
      OP_ADD: begin
        y     = sum[W-1:0];
        carry = sum[W];
        ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        y     = diff[W-1:0];
        carry = diff[W];
        ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NEGA: begin
        y   = '0 - a;
        ovf = (a == MIN_NEG);
      end
      OP_NEGB: begin
        y   = '0 - b;
        ovf = (b == MIN_NEG);
      end
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: handshake FSM, iterative shifter, shift-add multiplier
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int W  = 8,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         neg,
  output logic         carry,
  output logic         ovf,
  output logic         err
);

  state_t              state_q, state_d;
  logic [SW:0]         cnt_q;
  logic [3:0]          op_q;
  logic [W-1:0]        sh_q, sh_nx, mb_q, core_y, y_d;
  logic [2*W-1:0]      acc_q, acc_nx, mc_q;
  logic [FLAG_W-1:0]   st_q, st_d;
  logic [SW-1:0]       amt;
  logic                sh_c, core_c, core_v, res_c, res_v, res_e;
  logic                accept, last, load, iterate;

  alu_core #(.W(W)) u_core (
    .a     (a),
    .b     (b),
    .op    (op),
    .y     (core_y),
    .carry (core_c),
    .ovf   (core_v)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign amt       = b[SW-1:0];
  assign accept    = in_ready && in_valid;
  assign iterate   = (op == OP_MUL) || (is_shift(op) && (amt != '0));
  assign last      = (state_q == ITER) && (cnt_q == (SW+1)'(1));
  assign load      = (accept && !iterate) || last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = iterate ? ITER : DONE;
      ITER: if (cnt_q == (SW+1)'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One shift step or one multiplier bit per ITER cycle
  always_comb begin
    sh_nx  = sh_q;
    sh_c   = 1'b0;
    acc_nx = acc_q + (mb_q[0] ? mc_q : '0);
    case (op_q)
      OP_SHL: begin sh_nx = {sh_q[W-2:0], 1'b0};     sh_c = sh_q[W-1]; end
      OP_SHR: begin sh_nx = {1'b0, sh_q[W-1:1]};     sh_c = sh_q[0];   end
      OP_SAR: begin sh_nx = {sh_q[W-1], sh_q[W-1:1]}; sh_c = sh_q[0];  end
      default: sh_nx = sh_q;
    endcase
  end

  always_comb begin
    y_d   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    if (state_q == ITER) begin
      if (op_q == OP_MUL) begin
        y_d   = acc_nx[W-1:0];
        res_c = |acc_nx[2*W-1:W];
      end else begin
        y_d   = sh_nx;
        res_c = sh_c;
      end
    end else if (is_rsvd(op)) begin
      res_e = 1'b1;
    end else if (is_shift(op)) begin
      y_d = a;
    end else begin
      y_d   = core_y;
      res_c = core_c;
      res_v = core_v;
    end
    st_d             = '0;
    st_d[FLAG_ZERO]  = (y_d == '0);
    st_d[FLAG_NEG]   = y_d[W-1];
    st_d[FLAG_CARRY] = res_c;
    st_d[FLAG_OVF]   = res_v;
    st_d[FLAG_ERR]   = res_e;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      op_q  <= '0;
      sh_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      mc_q  <= '0;
      y     <= '0;
      st_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        sh_q  <= a;
        mb_q  <= b;
        mc_q  <= {{W{1'b0}}, a};
        acc_q <= '0;
        if (op == OP_MUL)     cnt_q <= (SW+1)'(W);
        else if (is_shift(op)) cnt_q <= {1'b0, amt};
        else                   cnt_q <= '0;
      end else if (state_q == ITER) begin
        sh_q  <= sh_nx;
        acc_q <= acc_nx;
        mc_q  <= mc_q << 1;
        mb_q  <= mb_q >> 1;
        cnt_q <= cnt_q - (SW+1)'(1);
      end
      if (load) begin
        y    <= y_d;
        st_q <= st_d;
      end
    end
  end

  assign zero  = st_q[FLAG_ZERO];
  assign neg   = st_q[FLAG_NEG];
  assign carry = st_q[FLAG_CARRY];
  assign ovf   = st_q[FLAG_OVF];
  assign err   = st_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc at W=8 and W=16
module tb_alu_mc;
  import alu_mc_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  f;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   passed = 0;

  int dop [11] = '{2, 3, 3, 11, 9, 10, 12, 12, 6, 14, 2};
  int da  [11] = '{'h7F, 3, 5, 'h90, 'h81, 'h5A, 'h0F, 'h10, 'h80, 'h33, 1};
  int db  [11] = '{1, 5, 5, 3, 1, 0, 'h11, 'h10, 0, 'h44, 2};

  always #5 clk = ~clk;

  function automatic void chk(string nm, int w, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s W=%0d actual=0x%0h required=0x%0h", nm, w, act, expv);
  endfunction

  // Flags packed as {err, ovf, carry, neg, zero}; cyc holds the extra iteration latency
  function automatic exp_t model(int w, logic [3:0] o, logic [31:0] a, logic [31:0] b);
    longint unsigned mask, msb, aa, bb, r, p;
    longint sa;
    int n;
    logic c, v, er;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    aa   = 64'(a) & mask;
    bb   = 64'(b) & mask;
    n    = int'(bb % 64'(w));
    r = 0; c = 0; v = 0; er = 0;
    case (o)
      4'h0: r = aa;
      4'h1: r = ~aa & mask;
      4'h2: begin
        p = aa + bb; r = p & mask; c = ((p >> w) & 64'd1) != 0;
        v = ((aa & msb) == (bb & msb)) && ((r & msb) != (aa & msb));
      end
      4'h3: begin
        r = (aa - bb) & mask; c = aa < bb;
        v = ((aa & msb) != (bb & msb)) && ((r & msb) != (aa & msb));
      end
      4'h4: r = aa & bb;
      4'h5: r = aa | bb;
      4'h6: begin r = (64'd0 - aa) & mask; v = (aa == msb); end
      4'h7: begin r = (64'd0 - bb) & mask; v = (bb == msb); end
      4'h8: r = aa ^ bb;
      4'h9: begin
        r = (aa << n) & mask;
        c = (n == 0) ? 1'b0 : (((aa >> (w - n)) & 64'd1) != 0);
      end
      4'hA: begin
        r = aa >> n;
        c = (n == 0) ? 1'b0 : (((aa >> (n - 1)) & 64'd1) != 0);
      end
      4'hB: begin
        sa = longint'(aa | (((aa & msb) != 0) ? ~mask : 64'd0));
        r  = 64'(sa >>> n) & mask;
        c  = (n == 0) ? 1'b0 : (((sa >>> (n - 1)) & 64'sd1) != 0);
      end
      4'hC: begin p = aa * bb; r = p & mask; c = (p >> w) != 0; end
      default: er = 1'b1;
    endcase
    e.y   = 32'(r);
    e.f   = {er, v, c, (r & msb) != 0, r == 0};
    e.cyc = (o == 4'hC) ? w : ((o >= 4'h9 && o <= 4'hB) ? n : 0);
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gw
    localparam int WW = (g == 0) ? 8 : 16;

    logic          reset_n, in_valid, in_ready, out_valid, out_ready;
    logic          zero, neg, carry, ovf, err;
    logic [WW-1:0] a, b, y;
    logic [3:0]    op;
    int            cyc = 0;
    bit            fin = 1'b0;
    exp_t          q[$];

    always @(posedge clk) cyc <= cyc + 1;

    alu_mc #(.W(WW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf),
      .err       (err)
    );

    task automatic issue(input logic [3:0] o, input logic [WW-1:0] x, input logic [WW-1:0] z);
      exp_t e;
      int   wt;
      op = o; a = x; b = z; in_valid = 1'b1; wt = 0;
      while (!in_ready && wt < 400) begin @(negedge clk); wt++; end
      if (!in_ready) begin
        total++;
        $display("FAIL accept_timeout W=%0d in_ready=%0b required=1", WW, in_ready);
      end else begin
        e = model(WW, o, 32'(x), 32'(z));
        e.cyc = cyc + 1 + e.cyc;
        q.push_back(e);
      end
      @(negedge clk);
      op = 4'($urandom); a = WW'($urandom); b = WW'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    initial begin
      int wt;
      reset_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
      @(negedge clk); @(negedge clk);
      chk("reset_out_valid", WW, 32'(out_valid), 32'd0);
      chk("reset_in_ready", WW, 32'(in_ready), 32'd1);
      chk("reset_y", WW, 32'(y), 32'd0);
      chk("reset_flags", WW, 32'({err, ovf, carry, neg, zero}), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 11; i++) issue(4'(dop[i]), WW'(da[i]), WW'(db[i]));
      issue(OP_MUL, WW'($urandom), WW'($urandom));
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midmul_reset_out_valid", WW, 32'(out_valid), 32'd0);
      chk("midmul_reset_y", WW, 32'(y), 32'd0);
      chk("midmul_reset_flags", WW, 32'({err, ovf, carry, neg, zero}), 32'd0);
      chk("midmul_reset_in_ready", WW, 32'(in_ready), 32'd1);
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      issue(OP_ADD, WW'(1), WW'(2));
      for (int i = 0; i < 60; i++)
        issue(4'($urandom_range(0, 15)), WW'($urandom), WW'($urandom));
      wt = 0;
      while (q.size() != 0 && wt < 3000) begin @(negedge clk); wt++; end
      if (q.size() != 0) begin
        total++;
        $display("FAIL drain_timeout W=%0d pending=%0d required=0", WW, q.size());
      end
      fin = 1'b1;
    end

    initial begin
      bit   seen, hs;
      exp_t e;
      out_ready = 1'b0; seen = 1'b0; hs = 1'b0;
      forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
          if (hs) begin
            chk("in_ready_after_handoff", WW, 32'(in_ready), 32'd1);
            chk("out_valid_after_handoff", WW, 32'(out_valid), 32'd0);
            hs = 1'b0;
          end
          if (out_valid) begin
            if (!seen) begin
              if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_result W=%0d y=0x%0h required=no result", WW, y);
                e.y = 32'(y); e.f = {err, ovf, carry, neg, zero}; e.cyc = cyc;
              end else begin
                e = q.pop_front();
                chk("y", WW, 32'(y), e.y);
                chk("flags", WW, 32'({err, ovf, carry, neg, zero}), 32'(e.f));
                chk("latency", WW, 32'(cyc), 32'(e.cyc));
              end
              seen = 1'b1;
            end else begin
              chk("hold_y", WW, 32'(y), e.y);
              chk("hold_flags", WW, 32'({err, ovf, carry, neg, zero}), 32'(e.f));
              chk("hold_in_ready", WW, 32'(in_ready), 32'd0);
            end
          end
          out_ready = ($urandom_range(0, 2) == 0);
          if (out_valid && out_ready) begin seen = 1'b0; hs = 1'b1; end
        end else begin
          seen = 1'b0; hs = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gw[0].fin && gw[1].fin) && t < 60000) begin @(negedge clk); t++; end
    if (!(gw[0].fin && gw[1].fin)) begin
      total++;
      $display("FAIL global_timeout cycles=%0d required=completion", t);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
